pwm_fade_multi: RTL and testbench
=================================

Name: pwm_fade_multi

Overview:
- N-channel PWM generator with hardware fading. Each channel ramps its duty toward a programmable target by a programmable step once per PWM period.
- Duty changes take effect only at period boundaries, so outputs are glitch-free.
- Replaces fixed 3-channel direct-duty PWM. Sits between LED colour/fade controller logic and the RGB LED pins.

Parameters:
- NUM_CH, 3: number of PWM channels (>=1).
- PWM_INTERVAL, 1200: period in clk cycles (12 MHz clk -> 100 us).
- STEP_W, 8: width of per-channel ramp step.
- Derived: CW = $clog2(PWM_INTERVAL+1), so duty can equal PWM_INTERVAL (100%). IW = max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  channel config write strobe
- wr_ready  out  1  write accepted when high
- wr_ch  in  IW  channel index for write
- wr_target  in  CW  target duty, in clk cycles high per period
- wr_step  in  STEP_W  duty change per period; 0 = jump to target
- pwm_out  out  NUM_CH  PWM outputs, bit i = channel i
- busy  out  NUM_CH  bit i high while duty[i] != target[i]
- period_start  out  1  one-cycle pulse when count==0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at posedge):
  - count, all duty/target/step/pending registers = 0.
  - pwm_out = 0, busy = 0.
  - wr_ready = 0 during the reset cycle; it is 1 from the first cycle after rst deasserts.
- Reset mid-period: aborts immediately. The count restarts at 0 after release.
- Counter:
  - count runs 0..PWM_INTERVAL-1 and wraps to 0.
  - "Boundary" = the cycle where count==PWM_INTERVAL-1.
  - period_start = (count==0) && !rst.
- Outputs: pwm_out[i] = (count < duty[i]), combinational from registered state.
  - duty=0 gives constant low.
  - duty>=PWM_INTERVAL gives constant high.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready.
  - It loads pending_target[wr_ch] and pending_step[wr_ch].
  - wr_target > PWM_INTERVAL is clamped to PWM_INTERVAL.
  - wr_ch >= NUM_CH is accepted and discarded.
  - Later writes before a boundary overwrite earlier ones (last write wins).
- Commit: at the boundary edge, for every channel, target <= pending_target and step <= pending_step.
  - A write accepted on the boundary cycle itself bypasses and commits at that same edge.
- Ramp: at the same boundary edge, duty is updated using the newly committed target/step (T, S):
  - S==0: duty <= T.
  - duty < T: duty <= min(duty+S, T).
  - duty > T: duty <= max(duty-S, T).
  - Arithmetic is done in CW+1 bits: no wrap or overshoot, and duty never passes T.
- Latency: a write made at any point in period k affects duty in period k+1.
  - Fade from D0 to T with step S completes in ceil(|T-D0|/S) periods.
- busy[i] = (duty[i] != target[i]), from registered values.
- Duty never changes mid-period. Each period's output is a single contiguous high pulse starting at count 0.

Test Plan (NUM_CH=3, PWM_INTERVAL=10, STEP_W=4):
- Reset: hold rst 3 cycles mid-period -> pwm_out=0, busy=0, wr_ready=0 during rst. After release: count=0, period_start pulses on the first post-reset cycle, wr_ready=1.
- Jump: write ch0 target=4, step=0 at count=2 -> pwm_out[0] stays 0 for the rest of that period. Each following period: high for counts 0-3, low for 4-9. busy[0] never asserts.
- Fade up with clamp: ch1 target=10, step=3 from duty 0 -> duty sequence per period is 3, 6, 9, 10, 10. busy[1] is high until duty reaches 10, then pwm_out[1] is constant high.
- Fade down with clamp: ch1 at 10, write target=2, step=3 -> duty 7, 4, 2, 2, with no undershoot.
- Boundary write and last-write-wins:
  - Write ch2 target=5 at count=3, then target=8 at count=9 (boundary) -> next period duty[2]=8.
  - Write ch2 target=15 -> clamped, duty[2]=10.
- Invalid channel: write wr_ch=3, target=7 -> accepted (wr_ready=1), no channel's duty, target or busy changes.

Source files
------------

// File: rtl/pwm_fade_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_multi
// Purpose  : N-channel PWM with per-period duty ramping toward a target.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_multi #(
  parameter int NUM_CH       = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_W       = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [$clog2(PWM_INTERVAL+1)-1:0]             wr_target,
  input  logic [STEP_W-1:0]                             wr_step,
  output logic [NUM_CH-1:0]                             pwm_out,
  output logic [NUM_CH-1:0]                             busy,
  output logic                                          period_start
);

  localparam int CW = $clog2(PWM_INTERVAL + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Ramp arithmetic must hold both duty and step without wrapping.
  localparam int AW = ((CW > STEP_W) ? CW : STEP_W) + 1;
  localparam logic [CW-1:0] C_MAX  = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] C_LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     duty_q   [NUM_CH];
  logic [CW-1:0]     duty_d   [NUM_CH];
  logic [CW-1:0]     target_q [NUM_CH];
  logic [CW-1:0]     target_d [NUM_CH];
  logic [CW-1:0]     ptgt_q   [NUM_CH];
  logic [CW-1:0]     ptgt_d   [NUM_CH];
  logic [STEP_W-1:0] pstep_q  [NUM_CH];
  logic [STEP_W-1:0] pstep_d  [NUM_CH];

  logic          w_boundary;
  logic          w_accept;
  logic [CW-1:0] w_wr_tgt;

  function automatic logic [CW-1:0] ramp(input logic [CW-1:0] d,
                                         input logic [CW-1:0] t,
                                         input logic [STEP_W-1:0] s);
    logic [AW-1:0] de, te, se, r;
    de = AW'(d);
    te = AW'(t);
    se = AW'(s);
    r  = de;
    if (se == '0)
      r = te;
    else if (de < te)
      r = ((te - de) <= se) ? te : (de + se);
    else if (de > te)
      r = ((de - te) <= se) ? te : (de - se);
    return CW'(r);
  endfunction

  // The committed step is only consumed on the boundary edge where it is
  // loaded, so the ramp reads the pending step directly instead of a copy.
  always_comb begin
    w_boundary = (count_q == C_LAST);
    w_accept   = wr_valid && wr_ready;
    w_wr_tgt   = (wr_target > C_MAX) ? C_MAX : wr_target;
    count_d    = w_boundary ? '0 : (count_q + CW'(1));
    for (int i = 0; i < NUM_CH; i++) begin
      ptgt_d[i]   = ptgt_q[i];
      pstep_d[i]  = pstep_q[i];
      target_d[i] = target_q[i];
      duty_d[i]   = duty_q[i];
      if (w_accept && (wr_ch == IW'(i))) begin
        ptgt_d[i]  = w_wr_tgt;
        pstep_d[i] = wr_step;
      end
      if (w_boundary) begin
        target_d[i] = ptgt_d[i];
        duty_d[i]   = ramp(duty_q[i], ptgt_d[i], pstep_d[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]   <= '0;
        target_q[i] <= '0;
        ptgt_q[i]   <= '0;
        pstep_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]   <= duty_d[i];
        target_q[i] <= target_d[i];
        ptgt_q[i]   <= ptgt_d[i];
        pstep_q[i]  <= pstep_d[i];
      end
    end
  end

  always_comb begin
    wr_ready     = !rst;
    period_start = (count_q == '0) && !rst;
    pwm_out      = '0;
    busy         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_out[i] = (count_q < duty_q[i]);
      busy[i]    = (duty_q[i] != target_q[i]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_multi
// Purpose  : Scoreboard bench for pwm_fade_multi against a period-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_multi;

  localparam int NUM_CH       = 3;
  localparam int PWM_INTERVAL = 10;
  localparam int STEP_W       = 4;
  localparam int CW           = 4;
  localparam int IW           = 2;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              wr_valid  = 1'b0;
  logic [IW-1:0]     wr_ch     = '0;
  logic [CW-1:0]     wr_target = '0;
  logic [STEP_W-1:0] wr_step   = '0;
  logic              wr_ready;
  logic              period_start;
  logic [NUM_CH-1:0] pwm_out;
  logic [NUM_CH-1:0] busy;

  always #5 clk = ~clk;

  pwm_fade_multi #(
    .NUM_CH      (NUM_CH),
    .PWM_INTERVAL(PWM_INTERVAL),
    .STEP_W      (STEP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_target   (wr_target),
    .wr_step     (wr_step),
    .pwm_out     (pwm_out),
    .busy        (busy),
    .period_start(period_start)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] bsy;
    logic              ps;
    logic              rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference state: the count within the period and per-channel settings.
  int m_count;
  int m_duty  [NUM_CH];
  int m_tgt   [NUM_CH];
  int m_ptgt  [NUM_CH];
  int m_pstep [NUM_CH];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int idx, t, s;
    if (rst) begin
      m_count = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_duty[i] = 0; m_tgt[i] = 0; m_ptgt[i] = 0; m_pstep[i] = 0;
      end
    end else begin
      idx = int'(wr_ch);
      if (wr_valid && idx < NUM_CH) begin
        m_ptgt[idx]  = (int'(wr_target) > PWM_INTERVAL) ? PWM_INTERVAL : int'(wr_target);
        m_pstep[idx] = int'(wr_step);
      end
      if (m_count == PWM_INTERVAL - 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
          t = m_ptgt[i];
          s = m_pstep[i];
          m_tgt[i] = t;
          if (s == 0)             m_duty[i] = t;
          else if (m_duty[i] < t) m_duty[i] = (m_duty[i] + s > t) ? t : m_duty[i] + s;
          else                    m_duty[i] = (m_duty[i] - s < t) ? t : m_duty[i] - s;
        end
      end
      m_count = (m_count + 1) % PWM_INTERVAL;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      e.pwm[i] = (m_count < m_duty[i]);
      e.bsy[i] = (m_duty[i] != m_tgt[i]);
    end
    e.ps  = (m_count == 0) && !rst;
    e.rdy = !rst;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic r, input logic v, input int ch, input int t, input int s);
    @(posedge clk);
    model_edge();
    #1;
    rst       = r;
    wr_valid  = v;
    wr_ch     = IW'(ch);
    wr_target = CW'(t);
    wr_step   = STEP_W'(s);
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Leaves the bench so that the next tick drives inputs during count == c.
  task automatic wait_before(input int c);
    for (int k = 0; k < 2 * PWM_INTERVAL && m_count != (c + PWM_INTERVAL - 1) % PWM_INTERVAL; k++)
      idle(1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("pwm_out", int'(pwm_out), int'(e_mon.pwm));
      check("busy", int'(busy), int'(e_mon.bsy));
      check("period_start/wr_ready", int'({period_start, wr_ready}), int'({e_mon.ps, e_mon.rdy}));
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 0, 0, 0);
    idle(4);
    // Reset held mid-period, then released.
    wait_before(5);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 0, 0, 0);
    idle(3);
    // Jump on ch0.
    wait_before(2);
    tick(1'b0, 1'b1, 0, 4, 0);
    idle(25);
    // Fade up then down on ch1.
    tick(1'b0, 1'b1, 1, 10, 3);
    idle(60);
    tick(1'b0, 1'b1, 1, 2, 3);
    idle(50);
    // Last write wins, including a boundary-cycle write, then clamp.
    wait_before(3);
    tick(1'b0, 1'b1, 2, 5, 0);
    wait_before(9);
    tick(1'b0, 1'b1, 2, 8, 0);
    idle(20);
    tick(1'b0, 1'b1, 2, 15, 2);
    idle(40);
    // Out-of-range channel index.
    tick(1'b0, 1'b1, 3, 7, 1);
    idle(20);
    for (int k = 0; k < 600; k++) begin
      tick(($urandom % 64) == 0, ($urandom % 3) == 0, int'($urandom % 4),
           int'($urandom % 16), (($urandom % 4) == 0) ? 0 : int'($urandom % 16));
    end
    idle(2);
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
